// File: rtl/buffer_drain_pkg.sv
// Shared definitions for the FIFO read-side drain: holding-store depth and
// the occupancy encoding used by the store and the issue logic.
package buffer_drain_pkg;
  localparam int STORE_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
endpackage

// File: rtl/buffer.sv
// Synchronous FIFO with registered read data and a combinational empty flag
// derived from the occupancy counter.
module buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  do_write, do_read;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(BUFFER_DEPTH));
  assign do_write = write_en && !full;
  assign do_read  = read_en && !empty;
  assign dout     = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    count_d = count_q + (AW+1)'(do_write) - (AW+1)'(do_read);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end
endmodule

// File: rtl/buffer_drain_skid_store2.sv
// Two-entry ordered holding store. Entry 0 is always the head; a pop shifts
// entry 1 forward and a push lands just behind whatever survives the pop.
module skid_store2
  import buffer_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_e                  occ,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d, entry1_q, entry1_d;
  occ_e                  occ_q, occ_d;
  logic [1:0]            base;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    base     = occ_q - {1'b0, pop};
    if (pop) entry0_d = entry1_q;
    if (push) begin
      if (base == 2'd0) entry0_d = push_data;
      else              entry1_d = push_data;
    end
    occ_d = occ_e'(base + {1'b0, push});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= OCC_EMPTY;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = entry0_q;
endmodule

// File: rtl/buffer_drain.sv
// Drains the synchronous FIFO into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a two-entry store; counts forwarded words.
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buf_empty,
  input  logic [DATA_WIDTH-1:0]  buf_dout,
  output logic                   buf_read_en,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] fwd_count
);
  occ_e                   occ;
  logic                   pop, accept;
  logic                   inflight_q, inflight_d;
  logic [COUNT_WIDTH-1:0] fwd_count_q, fwd_count_d;
  logic [2:0]             level;

  assign out_valid = (occ != OCC_EMPTY);
  assign pop       = out_valid && out_ready;

  // Occupancy the store will hold after this edge, with the same-cycle pop
  // credited so a full-rate stream keeps issuing a read every cycle.
  assign level       = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign buf_read_en = !rst && !buf_empty && (level < 3'd2);
  assign accept      = buf_read_en && !buf_empty;

  always_comb begin
    inflight_d  = accept;
    fwd_count_d = fwd_count_q + COUNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      fwd_count_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      fwd_count_q <= fwd_count_d;
    end
  end

  skid_store2 #(.DATA_WIDTH(DATA_WIDTH)) u_store (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (buf_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (out_data)
  );

  assign fwd_count = fwd_count_q;
endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench: FIFO feeding buffer_drain, plus a narrow-counter pair for
// the wrap case.
module tb_buffer_drain;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_en2 = 1'b0;
  logic [31:0] wr_data = '0, wr_data2 = '0;
  logic        out_ready = 1'b0, out_ready2 = 1'b0;
  logic        buf_empty, buf_full, buf_read_en, out_valid;
  logic [31:0] buf_dout, out_data;
  logic [15:0] fwd_count;
  logic        buf_empty2, buf_full2, buf_read_en2, out_valid2;
  logic [31:0] buf_dout2, out_data2;
  logic [3:0]  fwd_count2;

  int checks = 0, passed = 0;
  int cyc = 0, rd_cnt = 0, viol_rd = 0, viol_occ = 0;
  logic [31:0] rx_data[$];
  int          rx_cyc[$];

  always #5 clk = ~clk;

  buffer #(.DATA_WIDTH(32), .BUFFER_DEPTH(4)) u_fifo (
    .clk(clk), .rst(rst), .write_en(wr_en), .din(wr_data),
    .read_en(buf_read_en), .dout(buf_dout), .empty(buf_empty), .full(buf_full)
  );
  buffer_drain #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_dout(buf_dout),
    .buf_read_en(buf_read_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fwd_count(fwd_count)
  );
  buffer #(.DATA_WIDTH(32), .BUFFER_DEPTH(4)) u_fifo2 (
    .clk(clk), .rst(rst), .write_en(wr_en2), .din(wr_data2),
    .read_en(buf_read_en2), .dout(buf_dout2), .empty(buf_empty2), .full(buf_full2)
  );
  buffer_drain #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .buf_empty(buf_empty2), .buf_dout(buf_dout2),
    .buf_read_en(buf_read_en2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .fwd_count(fwd_count2)
  );

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_cyc.push_back(cyc);
      end
      if (buf_read_en && buf_empty) viol_rd++;
      if (buf_read_en && !buf_empty) rd_cnt++;
      if (int'(dut.occ) > 2) viol_occ++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_en2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rx_data.delete(); rx_cyc.delete();
    rd_cnt = 0; viol_rd = 0; viol_occ = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    sample();
    checks++; if (buf_read_en !== 1'b0) $display("FAIL reset_rd_en_in_rst got %0b want 0", buf_read_en); else passed++;
    tick();
    rst = 1'b0;
    sample();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_data got %h want 0", out_data); else passed++;
    checks++; if (fwd_count !== 16'h0) $display("FAIL reset_count got %0d want 0", fwd_count); else passed++;
    checks++; if (buf_read_en !== 1'b0) $display("FAIL reset_rd_en_idle got %0b want 0", buf_read_en); else passed++;
    checks++; if (fwd_count2 !== 4'h0) $display("FAIL reset_count2 got %0d want 0", fwd_count2); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    sample();
    checks++; if (buf_read_en !== 1'b1) $display("FAIL single_rd_en got %0b want 1", buf_read_en); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t0 got %0b want 0", out_valid); else passed++;
    tick(); sample();
    checks++; if (buf_read_en !== 1'b0) $display("FAIL single_rd_en_once got %0b want 0", buf_read_en); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t1 got %0b want 0", out_valid); else passed++;
    tick(); sample();
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid_t2 got %0b want 1", out_valid); else passed++;
    checks++; if (out_data !== 32'hDEADBEEF) $display("FAIL single_data got %h want deadbeef", out_data); else passed++;
    tick(); sample();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t3 got %0b want 0", out_valid); else passed++;
    checks++; if (fwd_count !== 16'd1) $display("FAIL single_count got %0d want 1", fwd_count); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    repeat (10) tick();
    checks++; if (rx_data.size() != 4) $display("FAIL stream_size got %0d want 4", rx_data.size()); else passed++;
    if (rx_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_data[i] !== 32'(i + 1)) $display("FAIL stream_data[%0d] got %0d want %0d", i, rx_data[i], i + 1); else passed++;
      end
      checks++; if (rx_cyc[3] - rx_cyc[0] != 3) $display("FAIL stream_gapless got span %0d want 3", rx_cyc[3] - rx_cyc[0]); else passed++;
    end
    checks++; if (fwd_count !== 16'd4) $display("FAIL stream_count got %0d want 4", fwd_count); else passed++;
    checks++; if (buf_empty !== 1'b1) $display("FAIL stream_fifo_empty got %0b want 1", buf_empty); else passed++;
  endtask

  task automatic test_backpressure();
    int held_bad;
    held_bad = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (!out_valid || out_data !== 32'd1) held_bad++;
      tick();
    end
    checks++; if (rd_cnt != 2) $display("FAIL bp_reads got %0d want 2", rd_cnt); else passed++;
    checks++; if (int'(dut.occ) != 2) $display("FAIL bp_occ got %0d want 2", int'(dut.occ)); else passed++;
    checks++; if (held_bad != 0) $display("FAIL bp_head_held got %0d bad cycles want 0", held_bad); else passed++;
    checks++; if (rx_data.size() != 0) $display("FAIL bp_no_pop got %0d want 0", rx_data.size()); else passed++;
    out_ready = 1'b1;
    sample();
    checks++; if (buf_read_en !== 1'b1) $display("FAIL bp_resume got %0b want 1", buf_read_en); else passed++;
    repeat (10) tick();
    checks++; if (rx_data.size() != 4) $display("FAIL bp_size got %0d want 4", rx_data.size()); else passed++;
    if (rx_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_data[i] !== 32'(i + 1)) $display("FAIL bp_data[%0d] got %0d want %0d", i, rx_data[i], i + 1); else passed++;
      end
      checks++; if (rx_cyc[3] - rx_cyc[0] != 3) $display("FAIL bp_gapless got span %0d want 3", rx_cyc[3] - rx_cyc[0]); else passed++;
    end
    checks++; if (fwd_count !== 16'd4) $display("FAIL bp_count got %0d want 4", fwd_count); else passed++;
  endtask

  task automatic test_toggle();
    int nxt;
    nxt = 0;
    do_reset();
    for (int c = 0; c < 400 && rx_data.size() < 32; c++) begin
      out_ready = c[0];
      wr_en = (nxt < 32) && !buf_full;
      wr_data = 32'(nxt);
      tick();
      if (wr_en) nxt++;
    end
    wr_en = 1'b0;
    checks++; if (rx_data.size() != 32) $display("FAIL toggle_size got %0d want 32", rx_data.size()); else passed++;
    if (rx_data.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (rx_data[i] !== 32'(i)) $display("FAIL toggle_data[%0d] got %0d want %0d", i, rx_data[i], i); else passed++;
      end
    end
    checks++; if (fwd_count !== 16'd32) $display("FAIL toggle_count got %0d want 32", fwd_count); else passed++;
    checks++; if (viol_occ != 0) $display("FAIL toggle_occ_overflow got %0d cycles want 0", viol_occ); else passed++;
    checks++; if (viol_rd != 0) $display("FAIL toggle_read_when_empty got %0d cycles want 0", viol_rd); else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      wr_en = (c < 4);
      wr_data = 32'(c + 1);
      tick();
      if (int'(dut.occ) == 1 && dut.inflight_q) found = 1'b1;
    end
    wr_en = 1'b0;
    rst = 1'b1;
    checks++; if (!found) $display("FAIL rmid_setup got no inflight state want occ=1 inflight=1"); else passed++;
    sample();
    checks++; if (buf_read_en !== 1'b0) $display("FAIL rmid_rd_en_in_rst got %0b want 0", buf_read_en); else passed++;
    tick();
    rst = 1'b0;
    sample();
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %0b want 0", out_valid); else passed++;
    checks++; if (fwd_count !== 16'd0) $display("FAIL rmid_count got %0d want 0", fwd_count); else passed++;
    checks++; if (out_data !== 32'd0) $display("FAIL rmid_data got %h want 0", out_data); else passed++;
    out_ready = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 32'hA5;
    tick();
    wr_en = 1'b0;
    sample();
    checks++; if (buf_read_en !== 1'b1) $display("FAIL rmid_post_rd_en got %0b want 1", buf_read_en); else passed++;
    tick(); sample();
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid_post_early got %0b want 0", out_valid); else passed++;
    tick(); sample();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5) $display("FAIL rmid_post_word got valid %0b data %h want 1 a5", out_valid, out_data); else passed++;
  endtask

  task automatic test_wrap();
    int npops, nxt;
    bit c16, done;
    npops = 0; nxt = 0; c16 = 1'b0; done = 1'b0;
    do_reset();
    out_ready2 = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (npops == 16 && !c16) begin
        c16 = 1'b1;
        checks++; if (fwd_count2 !== 4'd0) $display("FAIL wrap_after16 got %0d want 0", fwd_count2); else passed++;
      end
      if (npops == 17) begin
        done = 1'b1;
        checks++; if (fwd_count2 !== 4'd1) $display("FAIL wrap_after17 got %0d want 1", fwd_count2); else passed++;
      end
      wr_en2 = (nxt < 17) && !buf_full2;
      wr_data2 = 32'(nxt);
      sample();
      if (out_valid2 && out_ready2) npops++;
      tick();
      if (wr_en2) nxt++;
    end
    wr_en2 = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL wrap_timeout got %0d pops want 17", npops);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
